// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch-stage program counter generator with circular return-address stack
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter logic [XLEN-1:0] TRAP_VEC   = 'h80,
  parameter int              INST_BYTES = 4,
  parameter int              RAS_DEPTH  = 4
) (
  input  logic                         pc_clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         halt,
  input  logic                         trap_req,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_target,
  input  logic                         ras_push,
  input  logic [XLEN-1:0]              ras_push_addr,
  input  logic                         ret_pred,
  output logic [XLEN-1:0]              pc_out,
  output logic                         pc_valid,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            pc_valid_q, pc_valid_d;
  logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
  logic [CW-1:0]   ras_count_q, ras_count_d;
  logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_mem_d [RAS_DEPTH];

  logic            do_push;
  logic            do_pop;
  logic            ras_clear;
  logic            ras_has_entry;
  logic [PW-1:0]   ptr_inc;
  logic [PW-1:0]   ptr_dec;

  assign ras_has_entry = (ras_count_q != '0);
  assign ptr_inc       = ras_ptr_q + PW'(1);
  assign ptr_dec       = ras_ptr_q - PW'(1);

  // Next-PC selection and state transitions; trap and redirect dominate halt/stall.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = pc_valid_q;
    do_push    = 1'b0;
    do_pop     = 1'b0;
    ras_clear  = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d    = ST_RUN;
        pc_valid_d = 1'b1;
      end
      ST_RUN: begin
        if (trap_req) begin
          pc_d      = TRAP_VEC;
          ras_clear = 1'b1;
        end else if (redirect_valid) begin
          pc_d = redirect_target;
        end else if (halt) begin
          state_d    = ST_HALT;
          pc_valid_d = 1'b0;
        end else if (!stall) begin
          do_push = ras_push;
          if (ret_pred && ras_has_entry) begin
            do_pop = 1'b1;
            pc_d   = ras_mem_q[ras_ptr_q];
          end else begin
            pc_d = pc_q + XLEN'(INST_BYTES);
          end
        end
      end
      ST_HALT: begin
        if (trap_req) begin
          pc_d       = TRAP_VEC;
          ras_clear  = 1'b1;
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end else if (redirect_valid) begin
          pc_d       = redirect_target;
          state_d    = ST_RUN;
          pc_valid_d = 1'b1;
        end
      end
      default: begin
        state_d    = ST_BOOT;
        pc_valid_d = 1'b0;
      end
    endcase
  end

  // RAS bookkeeping: a push paired with a pop overwrites the current top in place.
  always_comb begin
    ras_ptr_d   = ras_ptr_q;
    ras_count_d = ras_count_q;
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_mem_d[i] = ras_mem_q[i];
    end
    if (ras_clear) begin
      ras_ptr_d   = '0;
      ras_count_d = '0;
    end else if (do_push && do_pop) begin
      ras_mem_d[ras_ptr_q] = ras_push_addr;
    end else if (do_push) begin
      ras_mem_d[ptr_inc] = ras_push_addr;
      ras_ptr_d          = ptr_inc;
      if (ras_count_q != CW'(RAS_DEPTH)) begin
        ras_count_d = ras_count_q + CW'(1);
      end
    end else if (do_pop) begin
      ras_ptr_d   = ptr_dec;
      ras_count_d = ras_count_q - CW'(1);
    end
  end

  // Control and PC registers with asynchronous reset.
  always_ff @(posedge pc_clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      pc_q        <= RESET_VEC;
      pc_valid_q  <= 1'b0;
      ras_ptr_q   <= '0;
      ras_count_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pc_valid_q  <= pc_valid_d;
      ras_ptr_q   <= ras_ptr_d;
      ras_count_q <= ras_count_d;
    end
  end

  // RAS storage keeps its contents across reset; only pointer and count reset.
  always_ff @(posedge pc_clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) begin
      ras_mem_q[i] <= ras_mem_d[i];
    end
  end

  assign pc_out    = pc_q;
  assign pc_valid  = pc_valid_q;
  assign ras_count = ras_count_q;
  assign ras_empty = !ras_has_entry;

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - directed self-checking bench for pc_gen
module tb_pc_gen;

  logic        pc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        trap_req = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        ras_push = 1'b0;
  logic [31:0] ras_push_addr = '0;
  logic        ret_pred = 1'b0;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [2:0]  ras_count;
  logic        ras_empty;

  int total = 0;
  int bad = 0;

  pc_gen dut (
    .pc_clk          (pc_clk),
    .rst             (rst),
    .stall           (stall),
    .halt            (halt),
    .trap_req        (trap_req),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .ras_push        (ras_push),
    .ras_push_addr   (ras_push_addr),
    .ret_pred        (ret_pred),
    .pc_out          (pc_out),
    .pc_valid        (pc_valid),
    .ras_count       (ras_count),
    .ras_empty       (ras_empty)
  );

  always #5 pc_clk = ~pc_clk;

  task automatic step();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic idle();
    stall = 0; halt = 0; trap_req = 0; redirect_valid = 0;
    ras_push = 0; ret_pred = 0;
  endtask

  task automatic test_reset();
    logic [31:0] seq [3];
    seq[0] = 32'h4; seq[1] = 32'h8; seq[2] = 32'hC;
    idle();
    rst = 1;
    repeat (3) @(posedge pc_clk);
    #1;
    total++; if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin bad++; $display("FAIL reset_out pc=%h valid=%b exp pc=0 valid=0", pc_out, pc_valid); end
    total++; if (ras_count !== 3'd0 || ras_empty !== 1'b1) begin bad++; $display("FAIL reset_ras count=%0d empty=%b exp 0/1", ras_count, ras_empty); end
    rst = 0;
    #1;
    total++; if (pc_out !== 32'h0 || pc_valid !== 1'b0) begin bad++; $display("FAIL pre_boot pc=%h valid=%b exp 0/0", pc_out, pc_valid); end
    step();
    total++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin bad++; $display("FAIL boot pc=%h valid=%b exp 0/1", pc_out, pc_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (pc_out !== seq[i]) begin bad++; $display("FAIL seq%0d pc=%h exp=%h", i, pc_out, seq[i]); end
    end
  endtask

  task automatic test_priority();
    step();
    total++; if (pc_out !== 32'h10) begin bad++; $display("FAIL prio_start pc=%h exp=10", pc_out); end
    trap_req = 1; redirect_valid = 1; redirect_target = 32'h200; stall = 1;
    step();
    total++; if (pc_out !== 32'h80) begin bad++; $display("FAIL prio_trap pc=%h exp=80", pc_out); end
    idle(); redirect_valid = 1;
    step();
    total++; if (pc_out !== 32'h200) begin bad++; $display("FAIL prio_redirect pc=%h exp=200", pc_out); end
    idle(); stall = 1;
    repeat (2) step();
    total++; if (pc_out !== 32'h200 || pc_valid !== 1'b1) begin bad++; $display("FAIL prio_stall pc=%h valid=%b exp 200/1", pc_out, pc_valid); end
    idle();
  endtask

  task automatic test_ras_order();
    logic [31:0] pushes [3];
    logic [31:0] pcs [3];
    pushes[0] = 32'h104; pushes[1] = 32'h208; pushes[2] = 32'h30C;
    pcs[0] = 32'h204; pcs[1] = 32'h208; pcs[2] = 32'h20C;
    for (int i = 0; i < 3; i++) begin
      idle(); ras_push = 1; ras_push_addr = pushes[i];
      step();
      total++; if (pc_out !== pcs[i]) begin bad++; $display("FAIL push_pc%0d pc=%h exp=%h", i, pc_out, pcs[i]); end
    end
    total++; if (ras_count !== 3'd3 || ras_empty !== 1'b0) begin bad++; $display("FAIL push_count count=%0d empty=%b exp 3/0", ras_count, ras_empty); end
    idle(); stall = 1; ras_push = 1; ras_push_addr = 32'hDEAD; ret_pred = 1;
    step();
    total++; if (ras_count !== 3'd3 || pc_out !== 32'h20C) begin bad++; $display("FAIL stall_ras count=%0d pc=%h exp 3/20c", ras_count, pc_out); end
    idle(); redirect_valid = 1; redirect_target = 32'h400; ras_push = 1; ret_pred = 1;
    step();
    total++; if (ras_count !== 3'd3 || pc_out !== 32'h400) begin bad++; $display("FAIL redirect_ras count=%0d pc=%h exp 3/400", ras_count, pc_out); end
    for (int i = 0; i < 3; i++) begin
      idle(); ret_pred = 1;
      step();
      total++; if (pc_out !== pushes[2-i]) begin bad++; $display("FAIL pop%0d pc=%h exp=%h", i, pc_out, pushes[2-i]); end
    end
    total++; if (ras_count !== 3'd0 || ras_empty !== 1'b1) begin bad++; $display("FAIL pop_empty count=%0d empty=%b exp 0/1", ras_count, ras_empty); end
    step();
    total++; if (pc_out !== 32'h108 || ras_count !== 3'd0) begin bad++; $display("FAIL ret_empty pc=%h count=%0d exp 108/0", pc_out, ras_count); end
    idle();
  endtask

  task automatic test_overflow();
    logic [31:0] exp_pop [4];
    exp_pop[0] = 32'h50; exp_pop[1] = 32'h40; exp_pop[2] = 32'h30; exp_pop[3] = 32'h20;
    for (int i = 1; i <= 5; i++) begin
      idle(); ras_push = 1; ras_push_addr = 32'(i * 16);
      step();
    end
    total++; if (ras_count !== 3'd4) begin bad++; $display("FAIL ovf_count count=%0d exp=4", ras_count); end
    for (int i = 0; i < 4; i++) begin
      idle(); ret_pred = 1;
      step();
      total++; if (pc_out !== exp_pop[i]) begin bad++; $display("FAIL ovf_pop%0d pc=%h exp=%h", i, pc_out, exp_pop[i]); end
    end
    total++; if (ras_count !== 3'd0) begin bad++; $display("FAIL ovf_drain count=%0d exp=0", ras_count); end
    idle(); ras_push = 1; ras_push_addr = 32'h50;
    step();
    idle(); ras_push = 1; ras_push_addr = 32'h60; ret_pred = 1;
    step();
    total++; if (pc_out !== 32'h50 || ras_count !== 3'd1) begin bad++; $display("FAIL simul pc=%h count=%0d exp 50/1", pc_out, ras_count); end
    idle(); ret_pred = 1;
    step();
    total++; if (pc_out !== 32'h60 || ras_count !== 3'd0) begin bad++; $display("FAIL simul_top pc=%h count=%0d exp 60/0", pc_out, ras_count); end
    idle();
  endtask

  task automatic test_halt();
    idle(); redirect_valid = 1; redirect_target = 32'h38;
    step();
    idle(); ras_push = 1; ras_push_addr = 32'h900;
    step();
    idle();
    step();
    total++; if (pc_out !== 32'h40 || ras_count !== 3'd1) begin bad++; $display("FAIL halt_setup pc=%h count=%0d exp 40/1", pc_out, ras_count); end
    halt = 1;
    step();
    total++; if (pc_out !== 32'h40 || pc_valid !== 1'b0) begin bad++; $display("FAIL halt_enter pc=%h valid=%b exp 40/0", pc_out, pc_valid); end
    idle(); stall = 1; ret_pred = 1; ras_push = 1; ras_push_addr = 32'hABC;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (pc_out !== 32'h40 || pc_valid !== 1'b0 || ras_count !== 3'd1) begin bad++; $display("FAIL halt_hold%0d pc=%h valid=%b count=%0d exp 40/0/1", i, pc_out, pc_valid, ras_count); end
    end
    idle(); redirect_valid = 1; redirect_target = 32'h100;
    step();
    total++; if (pc_out !== 32'h100 || pc_valid !== 1'b1) begin bad++; $display("FAIL halt_exit pc=%h valid=%b exp 100/1", pc_out, pc_valid); end
    idle();
    step();
    total++; if (pc_out !== 32'h104 || pc_valid !== 1'b1) begin bad++; $display("FAIL halt_run pc=%h valid=%b exp 104/1", pc_out, pc_valid); end
    halt = 1;
    step();
    idle(); trap_req = 1;
    step();
    total++; if (pc_out !== 32'h80 || pc_valid !== 1'b1 || ras_count !== 3'd0) begin bad++; $display("FAIL halt_trap pc=%h valid=%b count=%0d exp 80/1/0", pc_out, pc_valid, ras_count); end
    idle();
  endtask

  task automatic test_wrap_reset();
    idle(); redirect_valid = 1; redirect_target = 32'hFFFF_FFFC;
    step();
    idle();
    step();
    total++; if (pc_out !== 32'h0) begin bad++; $display("FAIL wrap pc=%h exp=0", pc_out); end
    ras_push = 1; ras_push_addr = 32'h77;
    step();
    idle();
    total++; if (pc_out !== 32'h4 || ras_count !== 3'd1) begin bad++; $display("FAIL pre_rst pc=%h count=%0d exp 4/1", pc_out, ras_count); end
    #2;
    rst = 1;
    #1;
    total++; if (pc_out !== 32'h0 || ras_count !== 3'd0 || pc_valid !== 1'b0) begin bad++; $display("FAIL async_rst pc=%h count=%0d valid=%b exp 0/0/0", pc_out, ras_count, pc_valid); end
    step();
    rst = 0;
    trap_req = 1;
    step();
    total++; if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin bad++; $display("FAIL boot_ignore pc=%h valid=%b exp 0/1", pc_out, pc_valid); end
    idle();
    step();
    total++; if (pc_out !== 32'h4) begin bad++; $display("FAIL post_boot pc=%h exp=4", pc_out); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_ras_order();
    test_overflow();
    test_halt();
    test_wrap_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined CPU's fetch stage.
- Produces the fetch address each cycle and selects the next PC from a fixed priority of sources: trap vector, pipeline redirect (branch/jump resolved in EX), return-address prediction, or sequential increment.
- Supports stall and halt.
- Contains a small circular return-address stack (RAS) fed by decode.

Parameters:
- XLEN, 32, PC/address width in bits.
- RESET_VEC, 0, PC value loaded on reset (XLEN bits).
- TRAP_VEC, 32'h0000_0080, PC loaded on trap_req (XLEN bits).
- INST_BYTES, 4, sequential increment in bytes.
- RAS_DEPTH, 4, RAS entries; power of two, at least 2.

Ports:
- pc_clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC (fetch/decode back-pressure).
- halt  in  1  enter HALT state.
- trap_req  in  1  redirect to TRAP_VEC; clears RAS.
- redirect_valid  in  1  EX-stage redirect (mispredict/jump) valid.
- redirect_target  in  XLEN  redirect address.
- ras_push  in  1  decode saw a call; push ras_push_addr.
- ras_push_addr  in  XLEN  return address to push.
- ret_pred  in  1  decode saw a return; next PC = RAS top.
- pc_out  out  XLEN  current fetch address (registered).
- pc_valid  out  1  pc_out is a valid fetch request.
- ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries.
- ras_empty  out  1  ras_count == 0.

Behaviour:
- Reset (asynchronous):
  - pc_out=RESET_VEC, pc_valid=0, state=BOOT.
  - RAS pointer=0, ras_count=0, ras_empty=1.
  - RAS contents are not cleared.
- States: BOOT, RUN, HALT.
  - BOOT lasts exactly one clock edge after rst deasserts. At that edge: state goes to RUN, pc_valid goes to 1, pc_out stays RESET_VEC. All other inputs are ignored during BOOT.
  - RUN: next PC chosen by priority, highest first:
    1. trap_req: pc_out<=TRAP_VEC; RAS cleared (count=0); no push or pop that cycle.
    2. redirect_valid: pc_out<=redirect_target; ras_push and ret_pred ignored (the decode instruction is squashed).
    3. halt: state->HALT, pc_valid<=0, pc_out held.
    4. stall: pc_out held; no RAS change.
    5. ret_pred && !ras_empty: pc_out<=RAS top; pop.
    6. Otherwise: pc_out<=pc_out+INST_BYTES.
  - In RUN, trap_req and redirect_valid override stall and halt.
  - ras_push in RUN without trap, redirect or stall: push, independent of which of cases 5–6 occurs.
  - ret_pred with ras_empty: treated as sequential (case 6), no pop, no error.
  - HALT: pc_out held, pc_valid=0, stall and RAS inputs ignored.
    - trap_req: pc_out<=TRAP_VEC, RAS cleared, state->RUN, pc_valid<=1.
    - redirect_valid: pc_out<=redirect_target, state->RUN, pc_valid<=1.
    - halt alone keeps the block in HALT.
- Arithmetic: increment is modulo 2^XLEN; all-ones+4 wraps to 3 for XLEN=32.
- RAS: circular, top pointer modulo RAS_DEPTH.
  - Push: write at ptr+1, ptr advances, count=min(count+1, RAS_DEPTH). On overflow the oldest entry is silently overwritten.
  - Pop: read entry at ptr, ptr retreats, count-1.
  - Simultaneous push and pop: the next PC is the old top. The pushed value replaces that same slot. ptr and count are unchanged.
- Latency: all outputs are registered. An input sampled at edge N is visible on pc_out after edge N.
- Reset mid-operation: immediate asynchronous return to the reset values; the next run starts at BOOT.

Test Plan:
- Reset/boot: hold rst 3 cycles, release → pc_out=0, pc_valid=0 for 1 cycle, then pc_valid=1; pc_out goes 0,4,8,C on the following edges.
- Priority: with pc_out=0x10, assert trap_req, redirect_valid (target 0x200) and stall in the same cycle → pc_out=0x80. Next cycle, redirect only → 0x200. Next cycle, stall only → stays 0x200.
- RAS order: push 0x104, 0x208, 0x30C, then ret_pred ×3 → pc_out sequence 0x30C, 0x208, 0x104. A fourth ret_pred with ras_empty=1 → pc_out+4.
- RAS overflow/simultaneous:
  - DEPTH=4: push 0x10,0x20,0x30,0x40,0x50 → ras_count=4; four pops give 0x50,0x40,0x30,0x20.
  - Push 0x60 and ret_pred in the same cycle with top=0x50 → pc_out=0x50, top becomes 0x60, count unchanged.
- Halt: assert halt at pc 0x40 → pc_valid=0, pc_out=0x40 held 5 cycles despite stall, ret_pred and ras_push. Then redirect_valid to 0x100 → pc_out=0x100, pc_valid=1, state RUN.
- Wrap and async reset: load pc 0xFFFFFFFC via redirect, step one cycle → 0x00000000. Assert rst between clock edges → pc_out=RESET_VEC and ras_count=0 immediately, without waiting for a clock edge.
